// File: rtl/axi_udp_pkg.sv
// axi_udp_pkg: shared types and constants for the UDP/ARP transmit path
package axi_udp_pkg;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
  localparam int BURST_W = 4;
  typedef enum logic [1:0] {TX_SRC_NONE = 2'd0, TX_SRC_ARP = 2'd1, TX_SRC_IP = 2'd2} tx_src_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ARP, ST_IP} arb_state_e;
endpackage

// File: rtl/axi_udp_tx_arb_if.sv
// axi_udp_tx_arb_if: byte-lane AXI-Stream link with tlast
interface axi_udp_tx_arb_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tdata;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axi_udp_axis_reg.sv
// axi_udp_axis_reg: single-stage registered AXI-Stream slice carrying data and tlast
module axi_udp_axis_reg #(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] q_data,
  output logic              q_last,
  output logic              q_valid,
  input  logic              q_ready
);
  assign ready = !q_valid || q_ready;
  // load on handshake, otherwise drain when the sink accepts; held while stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_data <= '0;
      q_last <= 1'b0;
      q_valid <= 1'b0;
    end else if (valid && ready) begin
      q_data <= data;
      q_last <= last;
      q_valid <= 1'b1;
    end else if (q_ready) q_valid <= 1'b0;
endmodule

// File: rtl/axi_udp_tx_arb.sv
// axi_udp_tx_arb: frame-granular ARP/IPv4 arbiter onto the MAC TX stream
module axi_udp_tx_arb import axi_udp_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int MAX_ARP_BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_udp_tx_arb_if.slave      s_arp,
  axi_udp_tx_arb_if.slave      s_ip,
  axi_udp_tx_arb_if.master     m,
  output tx_src_e              grant_src,
  output logic [CNT_W-1:0]     arp_frames,
  output logic [CNT_W-1:0]     ip_frames
);
  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_ARP_BURST);
  arb_state_e state, state_nx;
  logic [BURST_W-1:0] burst;
  logic rdy, sel_valid, sel_last, done, ip_turn;
  logic [DATA_W-1:0] sel_data;
  axi_udp_axis_reg #(.DATA_W(DATA_W)) u_reg (
    .clk(clk), .rst(rst),
    .data(sel_data), .last(sel_last), .valid(sel_valid), .ready(rdy),
    .q_data(m.tdata), .q_last(m.tlast), .q_valid(m.tvalid), .q_ready(m.tready)
  );
  assign s_arp.tready = state == ST_ARP && rdy;
  assign s_ip.tready = state == ST_IP && rdy;
  assign grant_src = state == ST_ARP ? TX_SRC_ARP : state == ST_IP ? TX_SRC_IP : TX_SRC_NONE;
  // owner mux and next-state: IDLE spends one cycle deciding, grant held until tlast accepted
  always_comb begin
    sel_valid = state == ST_ARP ? s_arp.tvalid : state == ST_IP ? s_ip.tvalid : 1'b0;
    sel_last = state == ST_ARP ? s_arp.tlast : s_ip.tlast;
    sel_data = state == ST_ARP ? s_arp.tdata : s_ip.tdata;
    done = sel_valid && rdy && sel_last;
    ip_turn = s_ip.tvalid && burst == MAX_B;
    state_nx = state;
    if (state == ST_IDLE) state_nx = s_arp.tvalid && !ip_turn ? ST_ARP : s_ip.tvalid ? ST_IP : ST_IDLE;
    else if (done) state_nx = ST_IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  // starvation guard counts ARP grants made while IPv4 waits; frame counters count accepted tlasts
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      burst <= '0;
      arp_frames <= '0;
      ip_frames <= '0;
    end else begin
      if (state == ST_IDLE && state_nx == ST_ARP) burst <= s_ip.tvalid ? burst + BURST_W'(burst != MAX_B) : '0;
      else if (state == ST_IDLE && state_nx == ST_IP) burst <= '0;
      if (done && state == ST_ARP) arp_frames <= arp_frames + 1'b1;
      if (done && state == ST_IP) ip_frames <= ip_frames + 1'b1;
    end
endmodule

// File: tb/tb_axi_udp_tx_arb.sv
// tb_axi_udp_tx_arb: table-driven, hand-written and randomized checks of the TX arbiter
module tb_axi_udp_tx_arb;
  import axi_udp_pkg::*;
  localparam int MAXB = 4;
  localparam int CW = 4;
  logic clk = 0, rst = 1;
  tx_src_e grant_src;
  logic [CW-1:0] arp_frames, ip_frames;
  axi_udp_tx_arb_if #(.DATA_W(8)) arp_if ();
  axi_udp_tx_arb_if #(.DATA_W(8)) ip_if ();
  axi_udp_tx_arb_if #(.DATA_W(8)) m_if ();
  axi_udp_tx_arb #(.DATA_W(8), .MAX_ARP_BURST(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s_arp(arp_if), .s_ip(ip_if), .m(m_if),
    .grant_src(grant_src), .arp_frames(arp_frames), .ip_frames(ip_frames)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [8:0] aq[$], iq[$], out_q[$];
  logic take_a, take_i, mid_a, mid_i, bub_a, bub_i;
  logic stall_en = 0, bubbles = 0, arp_only = 0, ip_rdy_seen = 0;
  logic in_fr, cur_src, prev_stall;
  logic [9:0] prev;
  int out_frames, mixed;
  string order;
  logic [6:0] seq = 0;

  typedef struct { int na; int ni; int la; int li; int ea; int ei; string ord; } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %s want %s", nm, act, exp);
    end
  endtask

  task automatic drive();
    arp_if.tvalid = aq.size() > 0 && !bub_a;
    arp_if.tdata = aq.size() > 0 ? aq[0][7:0] : 8'h00;
    arp_if.tlast = aq.size() > 0 && aq[0][8];
    ip_if.tvalid = iq.size() > 0 && !bub_i;
    ip_if.tdata = iq.size() > 0 ? iq[0][7:0] : 8'h00;
    ip_if.tlast = iq.size() > 0 && iq[0][8];
  endtask

  task automatic add_frame(input logic tag, input int len);
    for (int i = 0; i < len; i++) begin
      if (tag) iq.push_back({i == len - 1, tag, seq});
      else aq.push_back({i == len - 1, tag, seq});
      seq++;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1;
    aq.delete(); iq.delete(); out_q.delete();
    mid_a = 0; mid_i = 0; bub_a = 0; bub_i = 0;
    order = ""; out_frames = 0; in_fr = 0; mixed = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_grant", grant_src, TX_SRC_NONE);
    chk("rst_arp_frames", arp_frames, 0);
    chk("rst_ip_frames", ip_frames, 0);
    chk("rst_treadys", {arp_if.tready, ip_if.tready}, 0);
    rst = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int c = 0;
    while (out_frames < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #2 chk("frames_done", out_frames, n);
  endtask

  // source drivers and MAC ready: update just after each rising edge
  initial begin
    m_if.tready = 1;
    drive();
    forever begin
      @(posedge clk);
      #1;
      if (!rst && take_a) begin mid_a = !aq[0][8]; void'(aq.pop_front()); end
      if (!rst && take_i) begin mid_i = !iq[0][8]; void'(iq.pop_front()); end
      bub_a = mid_a && bubbles && $urandom_range(3) == 0;
      bub_i = mid_i && bubbles && $urandom_range(3) == 0;
      m_if.tready = stall_en ? 1'($urandom_range(1)) : 1'b1;
      drive();
    end
  end

  // monitor on the falling edge: record accepted beats, check hold while stalled
  initial begin
    prev_stall = 0;
    forever begin
      @(negedge clk);
      take_a = arp_if.tvalid && arp_if.tready;
      take_i = ip_if.tvalid && ip_if.tready;
      if (rst) prev_stall = 0;
      else begin
        if (prev_stall) begin
          checks++;
          if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== prev) begin
            errors++;
            $display("FAIL stall_hold got %h want %h", {m_if.tvalid, m_if.tlast, m_if.tdata}, prev);
          end
        end
        if (arp_only && ip_if.tready) ip_rdy_seen = 1;
        if (m_if.tvalid && m_if.tready) begin
          out_q.push_back({m_if.tlast, m_if.tdata});
          if (!in_fr) begin
            order = {order, m_if.tdata[7] ? "I" : "A"};
            cur_src = m_if.tdata[7];
            in_fr = 1;
          end else if (m_if.tdata[7] != cur_src) mixed++;
          if (m_if.tlast) begin in_fr = 0; out_frames++; end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev = {m_if.tvalid, m_if.tlast, m_if.tdata};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, nl;
    logic [8:0] ma[$], mi[$], exp_q[$], b;
    string eord;
    int na, ni, pa, pi, bc;
    tbl[0] = '{1, 0, 42, 1, 1, 0, "A"};
    tbl[1] = '{8, 2, 60, 60, 8, 2, "AAAAIAAAAI"};
    tbl[2] = '{0, 3, 1, 5, 0, 3, "III"};
    tbl[3] = '{2, 5, 1, 1, 2, 5, "AAIIIII"};
    tbl[4] = '{6, 1, 3, 3, 6, 1, "AAAAIAA"};
    tbl[5] = '{17, 0, 1, 1, 1, 0, "AAAAAAAAAAAAAAAAA"};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int k = 0; k < tbl[t].na; k++) add_frame(0, tbl[t].la);
      for (int k = 0; k < tbl[t].ni; k++) add_frame(1, tbl[t].li);
      drive();
      wait_done(tbl[t].na + tbl[t].ni, 3000);
      chk_s($sformatf("tbl%0d_order", t), order, tbl[t].ord);
      chk($sformatf("tbl%0d_arp_frames", t), arp_frames, tbl[t].ea);
      chk($sformatf("tbl%0d_ip_frames", t), ip_frames, tbl[t].ei);
      chk($sformatf("tbl%0d_beats", t), out_q.size(), tbl[t].na * tbl[t].la + tbl[t].ni * tbl[t].li);
      chk($sformatf("tbl%0d_mixed", t), mixed, 0);
    end
    // ARP-only frame: two-cycle latency, IPv4 never ready, single tlast at the end
    do_reset();
    arp_only = 1; ip_rdy_seen = 0;
    @(posedge clk);
    #2 add_frame(0, 42);
    drive();
    lat = 0;
    while (!m_if.tvalid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("arp_latency", lat, 2);
    wait_done(1, 200);
    arp_only = 0;
    nl = 0;
    foreach (out_q[i]) nl += int'(out_q[i][8]);
    chk("arp_beats", out_q.size(), 42);
    chk("arp_tlast_count", nl, 1);
    chk("arp_tlast_pos", out_q[out_q.size() - 1][8], 1);
    chk("arp_one_frame", arp_frames, 1);
    chk("ip_ready_seen", ip_rdy_seen, 0);
    // ARP shows up while an IPv4 frame is in flight
    do_reset();
    add_frame(1, 20);
    drive();
    repeat (8) @(posedge clk);
    #2 add_frame(0, 5);
    drive();
    wait_done(2, 300);
    chk_s("mid_order", order, "IA");
    chk("mid_mixed", mixed, 0);
    chk("mid_beats", out_q.size(), 25);
    // asynchronous reset in the middle of an IPv4 frame
    do_reset();
    add_frame(0, 2);
    drive();
    wait_done(1, 100);
    chk("pre_rst_arp_frames", arp_frames, 1);
    add_frame(1, 60);
    drive();
    lat = 0;
    while (out_q.size() < 12 && lat < 200) begin @(posedge clk); lat++; end
    chk("pre_rst_progress", out_q.size() >= 12, 1);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_m_tvalid", m_if.tvalid, 0);
    chk("arst_grant", grant_src, TX_SRC_NONE);
    chk("arst_arp_frames", arp_frames, 0);
    chk("arst_ip_frames", ip_frames, 0);
    chk("arst_ip_tready", ip_if.tready, 0);
    do_reset();
    add_frame(0, 3);
    drive();
    wait_done(1, 100);
    chk_s("post_rst_order", order, "A");
    chk("post_rst_arp_frames", arp_frames, 1);
    // randomized backlog with stalls and bubbles against a frame-level model
    for (int it = 0; it < 6; it++) begin
      do_reset();
      stall_en = 1; bubbles = 1;
      na = $urandom_range(0, 12); ni = $urandom_range(0, 6);
      for (int k = 0; k < na; k++) add_frame(0, $urandom_range(1, 8));
      for (int k = 0; k < ni; k++) add_frame(1, $urandom_range(1, 8));
      ma = aq; mi = iq; exp_q.delete(); eord = "";
      pa = na; pi = ni; bc = 0;
      while (pa > 0 || pi > 0) begin
        if (pa > 0 && !(pi > 0 && bc == MAXB)) begin
          bc = pi > 0 ? (bc < MAXB ? bc + 1 : bc) : 0;
          pa--; eord = {eord, "A"};
          do begin b = ma.pop_front(); exp_q.push_back(b); end while (!b[8]);
        end else begin
          bc = 0;
          pi--; eord = {eord, "I"};
          do begin b = mi.pop_front(); exp_q.push_back(b); end while (!b[8]);
        end
      end
      drive();
      wait_done(na + ni, 3000);
      stall_en = 0; bubbles = 0;
      chk_s($sformatf("rnd%0d_order", it), order, eord);
      chk($sformatf("rnd%0d_beats", it), out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
        chk($sformatf("rnd%0d_beat%0d", it, i), out_q[i], exp_q[i]);
      chk($sformatf("rnd%0d_arp_frames", it), arp_frames, na % 16);
      chk($sformatf("rnd%0d_ip_frames", it), ip_frames, ni % 16);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
